uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//   UART receive front end: recovers 8N1 serial frames from the asynchronous rx line.
//   Uses an N-times oversampled mid-bit sampler with start-bit glitch rejection.
//   Presents each byte through a one-entry valid/ready holding register.
//   Reports framing and overrun errors. Pairs with the UART transmitter (tx/start/done_tx).
// PARAMETERS
//   CLK_FREQ    50000000  system clock frequency, Hz
//   BAUD_RATE   19200     line rate, bit/s
//   DATA_WIDTH  8         data bits per frame, LSB first, no parity, 1 stop bit
//   OVERSAMPLE  16        ticks per bit; even, >= 4
// PORTS
//   clk          in   1           system clock, rising edge
//   rst          in   1           asynchronous, active-high reset
//   rx           in   1           serial input; idle high; asynchronous to clk
//   rx_ready     in   1           consumer accepts rx_data_out this cycle
//   rx_data_out  out  DATA_WIDTH  received byte; stable while rx_valid=1
//   rx_valid     out  1           rx_data_out holds an unconsumed byte
//   rx_active    out  1           frame in progress (START, DATA or STOP)
//   framing_err  out  1           1-cycle pulse: stop bit sampled low
//   overrun_err  out  1           1-cycle pulse: good frame dropped because holding register full
// BEHAVIOUR
//   Reset (async, any state, mid-frame included):
//   - rx_data_out=0; rx_valid, rx_active, framing_err, overrun_err = 0.
//   - State=IDLE; tick and bit counters cleared.
//   - Both synchronizer flops set to 1, so no false start after reset release.
//   - rx passes a 2-flop synchronizer (rx_s); all decisions use rx_s.
//   - Tick: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation, DIV >= 1 (162 at defaults).
//   - Tick counter counts 0..DIV-1 and emits a 1-clk tick on wrap. It restarts at 0 on IDLE->START.
//   FSM:
//   - IDLE: rx_s=0 -> START; clear tick count and sub-bit count s.
//   - START: on the tick where s reaches OVERSAMPLE/2-1, sample rx_s (mid start bit).
//     Sample 0 -> DATA with s=0. Sample 1 -> IDLE, treated as a glitch: no flag is raised.
//   - DATA: every OVERSAMPLE ticks, sample rx_s (mid bit) into the shift register, LSB first.
//     After DATA_WIDTH samples -> STOP.
//   - STOP: sample at the stop-bit mid-point.
//     Sample 1 -> deliver byte, then IDLE. Because IDLE is entered at mid-stop, back-to-back frames are received.
//     Sample 0 -> framing_err pulse, byte discarded, then RECOVER.
//   - RECOVER: wait for rx_s=1, then IDLE. A break (line held low) yields one framing_err only.
//   - rx_active=1 exactly in START/DATA/STOP.
//   Deliver (clock after the stop sample tick):
//   - If rx_valid=0, or rx_valid&rx_ready in the same cycle: load rx_data_out, rx_valid=1.
//   - Else: overrun_err pulse; rx_data_out keeps the old byte; new byte dropped.
//   Consume:
//   - rx_valid&rx_ready -> rx_valid=0 next clk, unless a deliver happens the same cycle (new byte wins, valid stays 1).
//   Latency: rx_valid rises 1 clk after the mid-stop sample tick, about 9.5 bit times after the start edge.
//   Tolerance: a frame is received correctly with a sender baud error of up to +/-3% at defaults.
// TESTING
//   1 Hold rst=1 with rx toggling, then release -> all outputs 0.
//     rx_active stays 0 until the first genuine start bit.
//   2 Send 0xA5 at 52083 ns/bit with rx_ready=0 -> rx_valid=1, rx_data_out=0xA5.
//     Values hold until rx_ready=1; rx_valid=0 one clk later.
//   3 With rx_ready=1, send 0x00 then 0xFF back-to-back (no idle gap), then 0x5A at +2% baud.
//     -> Three valid strobes, data 0x00, 0xFF, 0x5A in order; no error pulses.
//   4 Send 0x3C with stop bit driven 0 and hold rx low for 2 frame times, then release.
//     -> Exactly one framing_err pulse; rx_valid stays 0. A following 0x5A is received correctly.
//   5 Pulse rx low for 13 us (1/4 bit) -> rx_active rises then falls within START.
//     No rx_valid, no framing_err.
//   6 Overrun and reset:
//     - Send 0x11 with rx_ready=0, then send 0x22 -> one overrun_err pulse; rx_data_out stays 0x11.
//     - Assert rx_ready -> 0x11 consumed.
//     - Assert rst mid-way through a 0x77 frame -> outputs at reset values; no byte delivered.

Source files
------------

// File: rtl/uart_rx_oversampled_if.sv
// Byte handshake between the UART receiver (master) and its consumer (slave).
// The master holds rx_data_out/rx_valid until the slave takes it with rx_ready.
interface uart_rx_oversampled_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data_out;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output rx_data_out,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data_out,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: oversampled mid-bit sampling, start-glitch rejection,
// one-entry holding register with framing and overrun error pulses.
module uart_rx_oversampled #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  uart_rx_oversampled_if.master  bus,
  output logic                   rx_active,
  output logic                   framing_err,
  output logic                   overrun_err
);

  localparam int DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [S_W-1:0]    S_MID     = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]    S_LAST    = S_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } state_t;

  state_t                state_reg;
  logic                  rx_meta_reg;
  logic                  rx_s_reg;
  logic [TICK_W-1:0]     tick_cnt_reg;
  logic                  tick;
  logic [S_W-1:0]        s_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  valid_reg;
  logic                  active_reg;
  logic                  framing_err_reg;
  logic                  overrun_err_reg;

  // Flops reset to 1 (idle level) so releasing reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  assign tick = (tick_cnt_reg == TICK_LAST);

  // Held at zero while idle, so the first tick of a frame lands DIV clocks after the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_reg <= '0;
    end else if (state_reg == IDLE || tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      s_reg           <= '0;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      data_reg        <= '0;
      valid_reg       <= 1'b0;
      active_reg      <= 1'b0;
      framing_err_reg <= 1'b0;
      overrun_err_reg <= 1'b0;
    end else begin
      framing_err_reg <= 1'b0;
      overrun_err_reg <= 1'b0;
      if (valid_reg && bus.rx_ready) begin
        valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (!rx_s_reg) begin
            state_reg  <= START;
            s_reg      <= '0;
            active_reg <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (s_reg == S_MID) begin
              if (!rx_s_reg) begin
                state_reg   <= DATA;
                s_reg       <= '0;
                bit_cnt_reg <= '0;
              end else begin
                // Line back high at mid start bit: a glitch, silently ignored.
                state_reg  <= IDLE;
                active_reg <= 1'b0;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (s_reg == S_LAST) begin
              s_reg       <= '0;
              shift_reg   <= (shift_reg >> 1) | (DATA_WIDTH'(rx_s_reg) << (DATA_WIDTH - 1));
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == BIT_LAST) begin
                state_reg <= STOP;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (s_reg == S_LAST) begin
              active_reg <= 1'b0;
              if (rx_s_reg) begin
                // Back to IDLE at mid-stop so a back-to-back start edge is not missed.
                state_reg <= IDLE;
                if (!valid_reg || bus.rx_ready) begin
                  data_reg  <= shift_reg;
                  valid_reg <= 1'b1;
                end else begin
                  overrun_err_reg <= 1'b1;
                end
              end else begin
                state_reg       <= RECOVER;
                framing_err_reg <= 1'b1;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end

        RECOVER: begin
          if (rx_s_reg) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg  <= IDLE;
          active_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data_out = data_reg;
  assign bus.rx_valid    = valid_reg;
  assign rx_active       = active_reg;
  assign framing_err     = framing_err_reg;
  assign overrun_err     = overrun_err_reg;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: expected bytes are queued as frames
// are driven and compared when the receiver hands them over.
module tb_uart_rx_oversampled;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 390_625;    // DIV = 8, exactly 128 clocks per bit
  localparam int OS       = 16;
  localparam int DW       = 8;
  localparam int BIT_NS   = 2560;
  localparam int FAST_NS  = 2510;       // about +2% baud

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic rx_active;
  logic framing_err;
  logic overrun_err;

  uart_rx_oversampled_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_oversampled #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .bus        (bus.master),
    .rx_active  (rx_active),
    .framing_err(framing_err),
    .overrun_err(overrun_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int fe_cnt = 0;
  int oe_cnt = 0;
  int act_cnt = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Consumer side: a transfer happens on the next posedge whenever valid&ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (framing_err) fe_cnt++;
      if (overrun_err) oe_cnt++;
      if (rx_active) act_cnt++;
      if (bus.rx_valid && bus.rx_ready) begin
        pop_cnt++;
        $display("rx byte 0x%02h at %0t", bus.rx_data_out, $time);
        check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          check("rx_data", {24'b0, bus.rx_data_out}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send_frame(input logic [DW-1:0] d, input int bit_ns, input logic stop_val);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop_val;
    #(bit_ns);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
    check(tag, exp_q.size(), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 5000 && !bus.rx_valid; i++) @(negedge clk);
    check(tag, {31'b0, bus.rx_valid}, 32'd1);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.rx_ready = v;
  endtask

  int pops_before;
  int act_before;

  initial begin
    bus.rx_ready = 1'b0;

    // 1: reset with a toggling line, then idle release
    repeat (20) begin
      @(posedge clk);
      #1 rx = ~rx;
    end
    rx = 1'b1;
    #1;
    check("rst_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("rst_data", {24'b0, bus.rx_data_out}, 32'd0);
    check("rst_active", {31'b0, rx_active}, 32'd0);
    check("rst_ferr", {31'b0, framing_err}, 32'd0);
    check("rst_oerr", {31'b0, overrun_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(posedge clk);
    check("idle_no_active", act_cnt, 32'd0);

    // 2: hold a byte with rx_ready low, then consume it
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, BIT_NS, 1'b1);
    wait_valid("a5_valid");
    repeat (50) @(posedge clk);
    #1;
    check("a5_hold_valid", {31'b0, bus.rx_valid}, 32'd1);
    check("a5_hold_data", {24'b0, bus.rx_data_out}, 32'h0000_00A5);
    set_ready(1'b1);
    @(posedge clk);
    #1;
    check("a5_consumed", {31'b0, bus.rx_valid}, 32'd0);
    check("a5_popped", pop_cnt, 32'd1);

    // 3: back-to-back frames, then a fast sender
    exp_q.push_back(8'h00);
    send_frame(8'h00, BIT_NS, 1'b1);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, BIT_NS, 1'b1);
    #(BIT_NS);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, FAST_NS, 1'b1);
    wait_drain("b2b_drain");
    check("b2b_pops", pop_cnt, 32'd4);
    check("b2b_ferr", fe_cnt, 32'd0);
    check("b2b_oerr", oe_cnt, 32'd0);

    // 4: bad stop bit followed by a break
    send_frame(8'h3C, BIT_NS, 1'b0);
    #(20 * BIT_NS);
    rx = 1'b1;
    #(2 * BIT_NS);
    check("break_ferr", fe_cnt, 32'd1);
    check("break_no_byte", pop_cnt, 32'd4);
    check("break_valid", {31'b0, bus.rx_valid}, 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, BIT_NS, 1'b1);
    wait_drain("after_break_drain");

    // 5: short low glitch
    act_before = act_cnt;
    pops_before = pop_cnt;
    rx = 1'b0;
    #(BIT_NS / 4);
    rx = 1'b1;
    #(2 * BIT_NS);
    check("glitch_active_seen", {31'b0, act_cnt > act_before}, 32'd1);
    check("glitch_active_low", {31'b0, rx_active}, 32'd0);
    check("glitch_no_byte", pop_cnt, pops_before);
    check("glitch_ferr", fe_cnt, 32'd1);

    // 6: overrun, then reset mid-frame
    set_ready(1'b0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, BIT_NS, 1'b1);
    wait_valid("ovr_first_valid");
    send_frame(8'h22, BIT_NS, 1'b1);
    #(BIT_NS);
    check("ovr_pulse", oe_cnt, 32'd1);
    check("ovr_data_kept", {24'b0, bus.rx_data_out}, 32'h0000_0011);
    set_ready(1'b1);
    wait_drain("ovr_drain");

    pops_before = pop_cnt;
    fork
      send_frame(8'h77, BIT_NS, 1'b1);
    join_none
    #(4 * BIT_NS);
    check("mid_active", {31'b0, rx_active}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_active", {31'b0, rx_active}, 32'd0);
    check("mid_rst_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("mid_rst_data", {24'b0, bus.rx_data_out}, 32'd0);
    #(7 * BIT_NS);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (400) @(posedge clk);
    check("mid_rst_no_byte", pop_cnt, pops_before);
    check("final_ferr", fe_cnt, 32'd1);
    check("final_oerr", oe_cnt, 32'd1);
    check("final_queue", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
